// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SPI-mode SD command engine.
// Optional CRC7 generation is enabled with the SD_CRC7_GEN_EN macro.
package sd_spi_pkg;

    localparam int CMD_BITS = 48;
    localparam int BYTE_BITS = 8;
    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSLOW,
        ST_SEND,
        ST_POLL,
        ST_RECV,
        ST_TRAIL
    } state_t;

endpackage

// File: rtl/sd_spi_cmd_engine_if.sv
// Host-side register handshake between the SD controller and the
// SPI command engine: command, start, status and response bytes.
interface sd_spi_cmd_engine_if;
    import sd_spi_pkg::*;

    logic [CMD_BITS-1:0]  cmd;
    logic [2:0]           resp_len;
    logic                 start;
    logic                 busy;
    logic [BYTE_BITS-1:0] resp;
    logic                 resp_valid;
    logic                 done;
    logic                 timeout;

    modport master (
        output cmd, resp_len, start,
        input  busy, resp, resp_valid, done, timeout
    );

    modport slave (
        input  cmd, resp_len, start,
        output busy, resp, resp_valid, done, timeout
    );

endinterface

// File: rtl/sd_crc7.sv
// Serial SD CRC7 (x^7+x^3+1, init 0), one message bit per enable.
// Only instantiated when SD_CRC7_GEN_EN is defined.
import sd_spi_pkg::*;

module sd_crc7 (
    input  logic       clock,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic fb;

    assign fb = din ^ crc[6];

    // Shift the LFSR by one message bit per enable
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            crc <= 7'h00;
        end else if (clr) begin
            crc <= 7'h00;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_spi_cmd_engine.sv
// SPI-mode SD command engine: sends a 48-bit command, polls for R1,
// reads optional trailing bytes. SD_CRC7_GEN_EN replaces cmd[7:0] with CRC.
import sd_spi_pkg::*;

module sd_spi_cmd_engine #(
    parameter int CLK_DIV = 4,
    parameter int NCR_MAX = 8,
    parameter int TRAIL   = 8
) (
    input  logic                clock,
    input  logic                rst,
    sd_spi_cmd_engine_if.slave  host,
    input  logic                miso,
    output logic                sclk,
    output logic                mosi,
    output logic                cs_n
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t               state;
    logic [DW-1:0]        div_cnt;
    logic [5:0]           bit_cnt;
    logic [7:0]           poll_cnt;
    logic [2:0]           byte_cnt;
    logic [7:0]           trail_cnt;
    logic [2:0]           len_q;
    logic [CMD_BITS-1:0]  tx_sh;
    logic [CMD_BITS-1:0]  tx_next;
    logic [6:0]           rx_sh;
    logic [BYTE_BITS-1:0] rx_byte;
    logic [BYTE_BITS-1:0] resp_q;
    logic                 busy_q;
    logic                 rv_q;
    logic                 done_q;
    logic                 to_q;
    logic                 tick;
    logic                 rise;
    logic                 fall;
    logic                 accept;

    assign tick = (state != ST_IDLE) && (div_cnt == DW'(CLK_DIV - 1));
    assign rise = tick && !sclk;
    assign fall = tick && sclk;
    assign accept = (state == ST_IDLE) && host.start && !done_q;
    assign rx_byte = {rx_sh, miso};

`ifdef SD_CRC7_GEN_EN
    logic [6:0] crc;
    logic       crc_en;

    assign crc_en = ((state == ST_CSLOW) || (state == ST_SEND)) && rise &&
                    (bit_cnt < 6'(CMD_BITS - BYTE_BITS));

    sd_crc7 u_crc7 (
        .clock (clock),
        .rst   (rst),
        .clr   (accept),
        .en    (crc_en),
        .din   (tx_sh[CMD_BITS-1]),
        .crc   (crc)
    );

    assign tx_next = (bit_cnt == 6'(CMD_BITS - BYTE_BITS - 1)) ?
                     {crc, 1'b1, 40'd0} : {tx_sh[CMD_BITS-2:0], 1'b0};
`else
    assign tx_next = {tx_sh[CMD_BITS-2:0], 1'b0};
`endif

    assign host.busy = busy_q;
    assign host.resp = resp_q;
    assign host.resp_valid = rv_q;
    assign host.done = done_q;
    assign host.timeout = to_q;

    // Half-period divider, held at zero while idle
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if ((state == ST_IDLE) || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Transaction FSM with registered pin and status outputs
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            sclk      <= 1'b0;
            mosi      <= 1'b1;
            cs_n      <= 1'b1;
            busy_q    <= 1'b0;
            resp_q    <= 8'hFF;
            rv_q      <= 1'b0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
            bit_cnt   <= '0;
            poll_cnt  <= '0;
            byte_cnt  <= '0;
            trail_cnt <= '0;
            len_q     <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
        end else begin
            rv_q   <= 1'b0;
            done_q <= 1'b0;
            if (tick) sclk <= ~sclk;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_CSLOW;
                        busy_q    <= 1'b1;
                        cs_n      <= 1'b0;
                        to_q      <= 1'b0;
                        tx_sh     <= host.cmd;
                        len_q     <= host.resp_len;
                        mosi      <= host.cmd[CMD_BITS-1];
                        bit_cnt   <= '0;
                        poll_cnt  <= '0;
                        byte_cnt  <= '0;
                        trail_cnt <= '0;
                    end
                end
                ST_CSLOW: begin
                    if (tick) state <= ST_SEND;
                end
                ST_SEND: begin
                    if (fall) begin
                        if (bit_cnt == 6'(CMD_BITS - 1)) begin
                            state   <= ST_POLL;
                            mosi    <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                            tx_sh   <= tx_next;
                            mosi    <= tx_next[CMD_BITS-1];
                        end
                    end
                end
                ST_POLL: begin
                    if (rise) begin
                        rx_sh <= rx_byte[6:0];
                        if (bit_cnt == 6'(BYTE_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (!rx_byte[7]) begin
                                resp_q <= rx_byte;
                                rv_q   <= 1'b1;
                                state  <= (len_q == 3'd0) ? ST_TRAIL : ST_RECV;
                            end else if (poll_cnt == 8'(NCR_MAX - 1)) begin
                                resp_q <= 8'hFF;
                                to_q   <= 1'b1;
                                state  <= ST_TRAIL;
                            end else begin
                                poll_cnt <= poll_cnt + 8'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                ST_RECV: begin
                    if (rise) begin
                        rx_sh <= rx_byte[6:0];
                        if (bit_cnt == 6'(BYTE_BITS - 1)) begin
                            bit_cnt <= '0;
                            resp_q  <= rx_byte;
                            rv_q    <= 1'b1;
                            if (byte_cnt == len_q - 3'd1) begin
                                state <= ST_TRAIL;
                            end else begin
                                byte_cnt <= byte_cnt + 3'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                ST_TRAIL: begin
                    if (fall) begin
                        cs_n <= 1'b1;
                        mosi <= 1'b1;
                        if (trail_cnt == 8'(TRAIL)) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            trail_cnt <= trail_cnt + 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Self-checking bench for sd_spi_cmd_engine with an SD card model.
// Define SD_CRC7_GEN_EN for both RTL and bench to cover CRC generation.
module tb_sd_spi_cmd_engine;

    localparam int DIV = 4;
    localparam int NCR = 8;
    localparam int TRL = 8;

    typedef logic [7:0] bq_t[$];

    logic clock = 1'b0;
    logic rst = 1'b0;
    logic miso = 1'b1;
    logic sclk, mosi, cs_n;

    sd_spi_cmd_engine_if bus();

    sd_spi_cmd_engine #(.CLK_DIV(DIV), .NCR_MAX(NCR), .TRAIL(TRL)) dut (
        .clock (clock),
        .rst   (rst),
        .host  (bus),
        .miso  (miso),
        .sclk  (sclk),
        .mosi  (mosi),
        .cs_n  (cs_n)
    );

    always #5 clock = ~clock;

    int chk = 0;
    int pass = 0;
    int cyc = 0;
    int seen = 0;
    int rise_cnt = 0;
    int done_cnt = 0;
    int t0 = 0;
    int t1 = 0;
    bit mosi_bits[$];
    bit card_bits[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    bit exp_to;
    int exp_grp;
    logic snap_busy, snap_csn, snap_sclk, snap_mosi, snap_to, after_busy;
    logic [47:0] frame;

    always @(posedge clock) cyc <= cyc + 1;

    // Card side: capture DI on rising SCLK, drive DO on falling SCLK
    always @(posedge sclk) begin
        if (rise_cnt == 0) t0 = cyc;
        if (rise_cnt == 1) t1 = cyc;
        rise_cnt++;
        if (!cs_n) begin
            if (mosi_bits.size() < 48) mosi_bits.push_back(mosi);
            seen++;
        end
    end

    always @(negedge sclk) begin
        if (!cs_n && seen >= 48 && card_bits.size() > 0) miso = card_bits.pop_front();
        else miso = 1'b1;
    end

    always @(negedge clock) begin
        if (bus.resp_valid) got.push_back(bus.resp);
        if (bus.done) done_cnt++;
    end

    function automatic logic [47:0] exp_frame(input logic [47:0] c);
`ifdef SD_CRC7_GEN_EN
        logic [6:0] crc;
        logic fb;
        crc = 7'h00;
        for (int i = 47; i >= 8; i--) begin
            fb = c[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) crc = crc ^ 7'h09;
        end
        return {c[47:8], crc, 1'b1};
`else
        return c;
`endif
    endfunction

    // Reference: first byte with MSB clear within NCR polls, then len more
    task automatic model(input bq_t rb, input int len);
        logic [7:0] b;
        exp_q.delete();
        exp_to = 1'b1;
        exp_grp = 0;
        for (int i = 0; i < NCR; i++) begin
            b = (i < rb.size()) ? rb[i] : 8'hFF;
            exp_grp++;
            if (!b[7]) begin
                exp_q.push_back(b);
                for (int j = 1; j <= len; j++)
                    exp_q.push_back((i + j < rb.size()) ? rb[i + j] : 8'hFF);
                exp_grp += len;
                exp_to = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_txn(input logic [47:0] c, input logic [2:0] l,
                           input bq_t rb, input int mid_at, input bit poke);
        bit ok;
        card_bits.delete();
        foreach (rb[i]) for (int b = 7; b >= 0; b--) card_bits.push_back(rb[i][b]);
        mosi_bits.delete();
        got.delete();
        seen = 0;
        rise_cnt = 0;
        done_cnt = 0;
        @(negedge clock);
        bus.cmd = c;
        bus.resp_len = l;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        snap_busy = bus.busy;
        snap_csn = cs_n;
        snap_sclk = sclk;
        snap_mosi = mosi;
        snap_to = bus.timeout;
        ok = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clock);
            if (mid_at > 0 && n == mid_at) begin
                bus.cmd = ~c;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        bus.start = poke;
        chk++;
        if (!ok) $display("FAIL done_wait got none exp done within budget");
        else pass++;
        @(negedge clock);
        bus.start = 1'b0;
        after_busy = bus.busy;
        frame = '0;
        for (int i = 0; i < 48 && i < mosi_bits.size(); i++) frame[47 - i] = mosi_bits[i];
    endtask

    task automatic test_reset;
        chk++;
        if ({sclk, mosi, cs_n, bus.busy, bus.resp, bus.resp_valid, bus.done, bus.timeout}
            !== {3'b011, 1'b0, 8'hFF, 3'b000})
            $display("FAIL reset got %b%b%b%b %h %b%b%b exp 0110 ff 000",
                     sclk, mosi, cs_n, bus.busy, bus.resp, bus.resp_valid, bus.done, bus.timeout);
        else pass++;
    endtask

    task automatic test_cmd0;
        bq_t rb;
        rb = {8'hFF, 8'h01};
        model(rb, 0);
        run_txn(48'h400000000095, 3'd0, rb, 0, 1'b0);
        chk++;
        if ({snap_busy, snap_csn, snap_sclk, snap_mosi} !== 4'b1000)
            $display("FAIL cmd0_accept got %b%b%b%b exp 1000", snap_busy, snap_csn, snap_sclk, snap_mosi);
        else pass++;
        chk++;
        if (frame !== 48'h400000000095) $display("FAIL cmd0_frame got %h exp 400000000095", frame);
        else pass++;
        chk++;
        if (got.size() != 1 || got[0] !== 8'h01)
            $display("FAIL cmd0_resp got n=%0d %h exp n=1 01", got.size(), got.size() ? got[0] : 8'hxx);
        else pass++;
        chk++;
        if ({bus.timeout, bus.resp} !== {1'b0, 8'h01})
            $display("FAIL cmd0_status got %b %h exp 0 01", bus.timeout, bus.resp);
        else pass++;
        chk++;
        if (rise_cnt != 48 + 8 * exp_grp + TRL)
            $display("FAIL cmd0_sclk_count got %0d exp %0d", rise_cnt, 48 + 8 * exp_grp + TRL);
        else pass++;
        chk++;
        if (t1 - t0 != 2 * DIV) $display("FAIL sclk_period got %0d exp %0d", t1 - t0, 2 * DIV);
        else pass++;
        chk++;
        if (done_cnt != 1 || after_busy !== 1'b0)
            $display("FAIL cmd0_done got %0d busy %b exp 1 busy 0", done_cnt, after_busy);
        else pass++;
    endtask

    task automatic test_cmd8;
        bq_t rb;
        rb = {8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        run_txn(48'h48000001AA87, 3'd4, rb, 0, 1'b0);
        chk++;
        if (got.size() != 5) $display("FAIL cmd8_count got %0d exp 5", got.size());
        else pass++;
        foreach (rb[i]) begin
            chk++;
            if (i >= got.size() || got[i] !== rb[i])
                $display("FAIL cmd8_byte%0d got %h exp %h", i, (i < got.size()) ? got[i] : 8'hxx, rb[i]);
            else pass++;
        end
        chk++;
        if (rise_cnt != 48 + 40 + TRL) $display("FAIL cmd8_sclk_count got %0d exp %0d", rise_cnt, 88 + TRL);
        else pass++;
    endtask

    task automatic test_timeout;
        bq_t rb;
        rb = {};
        run_txn(48'h7A0000000001, 3'd4, rb, 0, 1'b0);
        chk++;
        if (got.size() != 0) $display("FAIL to_no_valid got %0d exp 0", got.size());
        else pass++;
        chk++;
        if ({bus.timeout, bus.resp} !== {1'b1, 8'hFF})
            $display("FAIL to_status got %b %h exp 1 ff", bus.timeout, bus.resp);
        else pass++;
        chk++;
        if (rise_cnt != 48 + 8 * NCR + TRL)
            $display("FAIL to_sclk_count got %0d exp %0d", rise_cnt, 48 + 8 * NCR + TRL);
        else pass++;
        repeat (5) @(negedge clock);
        chk++;
        if (bus.timeout !== 1'b1) $display("FAIL to_sticky got %b exp 1", bus.timeout);
        else pass++;
        rb = {8'h01};
        run_txn(48'h400000000095, 3'd0, rb, 0, 1'b0);
        chk++;
        if (snap_to !== 1'b0 || bus.timeout !== 1'b0)
            $display("FAIL to_clear got %b/%b exp 0/0", snap_to, bus.timeout);
        else pass++;
    endtask

    task automatic test_back_to_back;
        bq_t rb;
        logic [47:0] c;
        c = 48'h770000000065;
        rb = {8'hFF, 8'hFF, 8'h00};
        run_txn(c, 3'd0, rb, 50, 1'b1);
        chk++;
        if (frame !== exp_frame(c)) $display("FAIL b2b_frame got %h exp %h", frame, exp_frame(c));
        else pass++;
        chk++;
        if (done_cnt != 1) $display("FAIL b2b_done got %0d exp 1", done_cnt);
        else pass++;
        chk++;
        if (after_busy !== 1'b0) $display("FAIL done_cycle_start got busy %b exp 0", after_busy);
        else pass++;
        chk++;
        if (got.size() != 1 || got[0] !== 8'h00)
            $display("FAIL b2b_resp got n=%0d exp n=1 00", got.size());
        else pass++;
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        bus.cmd = 48'h400000000095;
        bus.resp_len = 3'd0;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (60) @(negedge clock);
        chk++;
        if ({bus.busy, cs_n} !== 2'b10) $display("FAIL mid_busy got %b%b exp 10", bus.busy, cs_n);
        else pass++;
        #2 rst = 1'b0;
        #1;
        chk++;
        if ({cs_n, sclk, bus.busy, mosi} !== 4'b1001)
            $display("FAIL mid_reset got %b%b%b%b exp 1001", cs_n, sclk, bus.busy, mosi);
        else pass++;
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_crc;
        bq_t rb;
        rb = {8'h01};
        run_txn(48'h400000000000, 3'd0, rb, 0, 1'b0);
        chk++;
`ifdef SD_CRC7_GEN_EN
        if (frame[7:0] !== 8'h95) $display("FAIL crc_last got %h exp 95", frame[7:0]);
        else pass++;
`else
        if (frame[7:0] !== 8'h00) $display("FAIL crc_last got %h exp 00", frame[7:0]);
        else pass++;
`endif
    endtask

    task automatic test_random;
        bq_t rb;
        logic [47:0] c;
        int len, pre;
        for (int it = 0; it < 8; it++) begin
            c = {2'b01, 14'($urandom), 32'($urandom)};
            len = $urandom_range(0, 7);
            pre = (it == 3) ? NCR : $urandom_range(0, NCR);
            rb = {};
            for (int i = 0; i < pre; i++) rb.push_back(8'h80 | 8'($urandom));
            rb.push_back(8'($urandom) & 8'h7F);
            for (int i = 0; i < len; i++) rb.push_back(8'($urandom));
            model(rb, len);
            run_txn(c, 3'(len), rb, 0, 1'b0);
            chk++;
            if (frame !== exp_frame(c)) $display("FAIL rnd%0d_frame got %h exp %h", it, frame, exp_frame(c));
            else pass++;
            chk++;
            if (got.size() != exp_q.size())
                $display("FAIL rnd%0d_count got %0d exp %0d", it, got.size(), exp_q.size());
            else pass++;
            foreach (exp_q[i]) begin
                chk++;
                if (i >= got.size() || got[i] !== exp_q[i])
                    $display("FAIL rnd%0d_byte%0d got %h exp %h", it, i,
                             (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
                else pass++;
            end
            chk++;
            if (bus.timeout !== exp_to || (exp_to && bus.resp !== 8'hFF))
                $display("FAIL rnd%0d_timeout got %b %h exp %b", it, bus.timeout, bus.resp, exp_to);
            else pass++;
            chk++;
            if (rise_cnt != 48 + 8 * exp_grp + TRL || done_cnt != 1)
                $display("FAIL rnd%0d_sclk got %0d done %0d exp %0d done 1", it, rise_cnt, done_cnt,
                         48 + 8 * exp_grp + TRL);
            else pass++;
        end
    endtask

    initial begin
        bus.cmd = '0;
        bus.resp_len = '0;
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clock);
        test_cmd0;
        test_cmd8;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        test_cmd0;
        test_crc;
        test_random;
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
